seven_display_scanner: RTL and testbench
========================================

# seven_display_scanner

Time-multiplexed scan controller that shares one `seven_display` decoder across `DIGITS` common-anode digits. It holds a double-buffered display image, steps through digits with a programmable dwell and anti-ghosting dead time, and drives the shared decoder's `value` input plus the active-low digit enables. A new image is committed only at frame boundaries, so a digit never shows half-updated data.

## Interface

Parameters:
- `DIGITS`, 4: number of digits scanned (≥2).
- `DWELL`, 50000: cycles each digit's anode is on (≥1).
- `BLANK`, 1000: dead-time cycles with all anodes off before each digit (≥1).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `load`  in  1  single-cycle strobe; captures `data_in`/`blank_in` into shadow.
- `data_in`  in  4*DIGITS  nibble per digit, digit i = bits [4i+3:4i].
- `blank_in`  in  DIGITS  1 = digit i suppressed (anode kept off).
- `value`  out  4  nibble to shared decoder.
- `digit_en`  out  DIGITS  active-low anode enables.
- `frame_start`  out  1  one-cycle pulse at start of each new frame.
- `pending`  out  1  shadow holds an uncommitted image.

## Operation

- Registers: active image (`act_data`, `act_blank`), shadow image (`shd_data`, `shd_blank`), `pending`, digit index `idx` (0..DIGITS-1), dwell counter `cnt`, 2-state FSM.
- `load`=1: shadow ← inputs, `pending` ← 1. Multiple loads before a commit: last wins.
- FSM S_BLANK: `digit_en` all 1; `cnt` counts 0..BLANK-1; at BLANK-1 → S_ON, `cnt` ← 0.
- FSM S_ON: `digit_en[idx]` = 0 iff `act_blank[idx]`=0, all other bits 1; `cnt` counts 0..DWELL-1; at DWELL-1 → S_BLANK, `cnt` ← 0, `idx` ← idx+1, wrapping DIGITS-1 → 0.
- Commit: on the S_ON→S_BLANK transition with `idx`=DIGITS-1, if `pending`=1, active ← shadow and `pending` ← 0.
- Load coincident with commit cycle: active ← `data_in`/`blank_in` directly, shadow also updated, `pending` ← 0.
- Load in any other cycle never alters active image.
- `value` = `act_data[4*idx +: 4]` in both states (decoder settles during dead time).
- `frame_start` registered: high for the first S_BLANK cycle of idx 0 following a wrap. Not asserted after reset.
- Reset values: state S_BLANK, `idx` 0, `cnt` 0, `act_data`/`shd_data` 0, `act_blank`/`shd_blank` all 1, `pending` 0, `frame_start` 0, `digit_en` all 1, `value` 0.
- `rst_n` low at any time (including mid-S_ON): all outputs take reset values immediately, asynchronously.

## Timing

- Digit period = BLANK+DWELL cycles; frame = DIGITS*(BLANK+DWELL).
- After `rst_n` release, first S_ON begins on cycle BLANK (edges counted from 0).
- `digit_en` and `frame_start` are registered; `value` is combinational from registers (no glitch beyond mux).
- Load-to-display latency: from load until next wrap, max one frame + 1 cycle.
- Two enable bits are never low simultaneously; ≥BLANK all-off cycles between any two anode-on windows.
- `pending` rises the cycle after `load`, falls the cycle after commit.

## Test plan

Bench parameters DIGITS=4, DWELL=4, BLANK=2 (period 6, frame 24).
- Reset: release `rst_n`, no load, 48 cycles -> `digit_en`=4'b1111 throughout, `value`=0, `pending`=0, `frame_start` 0 in the first frame then pulses only on wrap.
- Basic scan: load `data_in`=16'h4321, `blank_in`=0 mid-frame -> `pending`=1 until wrap; next frame: 2 cycles 1111/value 1, 4 cycles 1110/value 1, 2 cycles 1111/value 2, 4 cycles 1101/value 2, … 4 cycles 0111/value 4; `frame_start` pulse at frame start.
- Last-wins: load 16'h1111 then 16'hABCD before wrap -> value 1 never shown; frame shows D,C,B,A on digits 0..3.
- Coincident load: assert `load` with 16'h5678 exactly in commit cycle -> next frame displays 8,7,6,5; `pending` stays 0.
- Blank mask: load `blank_in`=4'b0100 -> `digit_en[2]` never 0; digits 0,1,3 scan normally; `value`=digit 2 nibble still presented during its slot.
- Mid-scan reset: assert `rst_n` low during S_ON of digit 1 -> `digit_en`=4'b1111 same cycle, image cleared, rescan restarts at idx 0 after release.

Source files
------------

// File: rtl/seven_display_scanner.sv
// Time-multiplexed scan controller for DIGITS common-anode digits sharing one
// seven-segment decoder. The display image is double-buffered and committed only at frame wrap.
//
// state   | meaning
// S_BLANK | dead time, all anodes off, decoder input settling for the upcoming digit
// S_ON    | anode of digit idx on (unless that digit is blanked)
module seven_display_scanner #(
  parameter int DIGITS = 4,
  parameter int DWELL  = 50000,
  parameter int BLANK  = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     blank_in,
  output logic [3:0]            value,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_start,
  output logic                  pending
);

  localparam int IW   = $clog2(DIGITS);
  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic {S_BLANK, S_ON} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   act_data_q, act_data_d;
  logic [4*DIGITS-1:0]   shd_data_q, shd_data_d;
  logic [DIGITS-1:0]     act_blank_q, act_blank_d;
  logic [DIGITS-1:0]     shd_blank_q, shd_blank_d;
  logic                  pending_q, pending_d;
  logic                  frame_start_q, frame_start_d;
  logic [DIGITS-1:0]     digit_en_q, digit_en_d;
  logic                  commit;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    act_data_d    = act_data_q;
    act_blank_d   = act_blank_q;
    shd_data_d    = shd_data_q;
    shd_blank_d   = shd_blank_q;
    pending_d     = pending_q;
    commit        = 1'b0;

    case (state_q)
      S_BLANK: begin
        if (cnt_q == CW'(BLANK - 1)) begin
          state_d = S_ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        if (cnt_q == CW'(DWELL - 1)) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          if (idx_q == IW'(DIGITS - 1)) begin
            idx_d  = '0;
            commit = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase

    // A load landing on the commit edge bypasses the shadow so it is not lost for a frame.
    if (load) begin
      shd_data_d  = data_in;
      shd_blank_d = blank_in;
      if (commit) begin
        act_data_d  = data_in;
        act_blank_d = blank_in;
        pending_d   = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end else if (commit && pending_q) begin
      act_data_d  = shd_data_q;
      act_blank_d = shd_blank_q;
      pending_d   = 1'b0;
    end

    frame_start_d = commit;

    // Enables are computed from next-state values so the registered output lines up with state_q.
    for (int i = 0; i < DIGITS; i++) begin
      digit_en_d[i] = !((state_d == S_ON) && (idx_d == IW'(i)) && !act_blank_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_BLANK;
      idx_q         <= '0;
      cnt_q         <= '0;
      act_data_q    <= '0;
      shd_data_q    <= '0;
      act_blank_q   <= '1;
      shd_blank_q   <= '1;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
      digit_en_q    <= '1;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      act_data_q    <= act_data_d;
      shd_data_q    <= shd_data_d;
      act_blank_q   <= act_blank_d;
      shd_blank_q   <= shd_blank_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
      digit_en_q    <= digit_en_d;
    end
  end

  always_comb begin
    value = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) value = act_data_q[4*i +: 4];
    end
  end

  assign digit_en    = digit_en_q;
  assign frame_start = frame_start_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_seven_display_scanner.sv
// Directed bench for seven_display_scanner at DIGITS=4, DWELL=4, BLANK=2 (period 6, frame 24).
// Expected outputs come from the frame position k and a small image/commit model.
module tb_seven_display_scanner;

  localparam int DIGITS = 4;
  localparam int DWELL  = 4;
  localparam int BLANK  = 2;
  localparam int PER    = BLANK + DWELL;
  localparam int FRAME  = DIGITS * PER;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  blank_in;
  logic [3:0]  value;
  logic [3:0]  digit_en;
  logic        frame_start;
  logic        pending;

  seven_display_scanner #(.DIGITS(DIGITS), .DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .data_in     (data_in),
    .blank_in    (blank_in),
    .value       (value),
    .digit_en    (digit_en),
    .frame_start (frame_start),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  // k = rising edges since reset release; model image state mirrors the expected registers.
  int          k;
  logic [15:0] m_act, m_shd;
  logic [3:0]  m_actb, m_shdb;
  logic        m_pend;
  int          n_vec, n_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    k      = 0;
    m_act  = '0;
    m_shd  = '0;
    m_actb = '1;
    m_shdb = '1;
    m_pend = 1'b0;
  endtask

  task automatic check_cycle();
    int pos, d, s;
    logic [3:0] en;
    pos = k % FRAME;
    d   = pos / PER;
    s   = pos % PER;
    en  = 4'b1111;
    if (s >= BLANK && !m_actb[d]) en[d] = 1'b0;
    chk("digit_en", 32'(digit_en), 32'(en));
    chk("value", 32'(value), 32'(m_act[4*d +: 4]));
    chk("frame_start", 32'(frame_start), 32'(k >= FRAME && pos == 0));
    chk("pending", 32'(pending), 32'(m_pend));
  endtask

  // Called just after a falling edge; drives inputs for the next rising edge.
  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] b);
    logic commit;
    load     = ld;
    data_in  = d;
    blank_in = b;
    commit   = ((k + 1) % FRAME == 0);
    if (ld) begin
      m_shd  = d;
      m_shdb = b;
      if (commit) begin
        m_act  = d;
        m_actb = b;
        m_pend = 1'b0;
      end else begin
        m_pend = 1'b1;
      end
    end else if (commit && m_pend) begin
      m_act  = m_shd;
      m_actb = m_shdb;
      m_pend = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    k++;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      check_cycle();
      step(1'b0, 16'h0, 4'h0);
    end
  endtask

  task automatic load_now(input logic [15:0] d, input logic [3:0] b);
    check_cycle();
    step(1'b1, d, b);
  endtask

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b0;
    load     = 1'b0;
    data_in  = '0;
    blank_in = '0;
    n_vec    = 0;
    n_mis    = 0;
    model_reset();

    repeat (2) @(negedge clk);
    check_cycle();
    rst_n = 1'b1;

    // Idle scan with reset image: all anodes off, frame_start only on wraps.
    run(48);

    // Basic scan: 4321 loaded mid-frame, displayed from the next wrap.
    run(10);
    load_now(16'h4321, 4'b0000);
    run(13 + 24);

    // Last load before the wrap wins.
    run(5);
    load_now(16'h1111, 4'b0000);
    run(3);
    load_now(16'hABCD, 4'b0000);
    run(14 + 24);

    // Load exactly on the commit edge goes straight to the active image.
    run(23);
    load_now(16'h5678, 4'b0000);
    run(24);

    // Digit 2 blanked: its anode stays off but its nibble is still presented.
    run(3);
    load_now(16'h9E2F, 4'b0100);
    run(44);

    // Asynchronous reset during S_ON of digit 1 with a pending image.
    run(2);
    load_now(16'h1234, 4'b0000);
    run(6);
    check_cycle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_cycle();
    repeat (2) @(negedge clk);
    check_cycle();
    rst_n = 1'b1;

    // Rescan restarts at idx 0 with a cleared image.
    run(6);
    load_now(16'hCAFE, 4'b0000);
    run(17 + 24);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
